i2c_slave_regfile: RTL and testbench

Synthesizable I2C target with an internal byte-wide register file, oversampling SCL/SDA on the bus clock. It sits directly downstream of the `i2c` master core on the same SCL/SDA pair and is used on-chip and in benches as the consumer of master transactions. Bus transactions use pointer-then-data protocol: the first written byte sets the register pointer, further bytes write or read with auto-increment. A fabric-side port reads registers and reports every I2C write as a one-cycle strobe.

---
 rtl/i2c_slave_regfile_if.sv | 13 +
 rtl/i2c_slave_regfile.sv | 231 +++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_regfile_if.sv
// Fabric-side port of i2c_slave_regfile: register read-back plus the strobe
// reporting every register written over I2C, and the bus-busy flag.
interface i2c_slave_regfile_if #(parameter int AW = 4);
  logic [AW-1:0] REG_ADDR;
  logic [7:0]    REG_DATA;
  logic          WR_STB;
  logic [AW-1:0] WR_ADDR;
  logic [7:0]    WR_DATA;
  logic          BUSY;

  modport master (output REG_ADDR, input REG_DATA, WR_STB, WR_ADDR, WR_DATA, BUSY);
  modport slave  (input REG_ADDR, output REG_DATA, WR_STB, WR_ADDR, WR_DATA, BUSY);
endinterface

// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte-wide register file (pointer-then-data, auto-increment).
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL/SDA.
module i2c_slave_regfile #(
  parameter logic [6:0] ADDRESS   = 7'b1001001,
  parameter int         MEM_BYTES = 16,
  parameter int         AW        = $clog2(MEM_BYTES)
) (
  input  logic BUS_CLK,
  input  logic BUS_RST,
  input  logic I2C_SCL,
  inout  wire  I2C_SDA,
  i2c_slave_regfile_if.slave fab
);
  typedef enum logic [2:0] {IDLE, ADDR, AACK, DATA_W, DACK_W, DATA_R, DACK_R, WAIT_STOP} state_t;

  logic scl_meta_q, scl_sync_q, sda_meta_q, sda_sync_q;
  logic scl_prev_q, sda_prev_q;
  logic scl_s, sda_s;

  // Sync flops reset high so an idle bus produces no edges after reset.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= I2C_SCL;
      scl_sync_q <= scl_meta_q;
      sda_meta_q <= I2C_SDA;
      sda_sync_q <= sda_meta_q;
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q, scl_filt_d, sda_filt_d;

  always_comb begin
    scl_filt_d = (scl_sync_q & scl_hist_q[0]) | (scl_sync_q & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[1]);
    sda_filt_d = (sda_sync_q & sda_hist_q[0]) | (sda_sync_q & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[1]);
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q};
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
    end
  end

  assign scl_s = scl_filt_q;
  assign sda_s = sda_filt_q;
`else
  assign scl_s = scl_sync_q;
  assign sda_s = sda_sync_q;
`endif

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          ptr_pend_q, ptr_pend_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          wr_stb_q, wr_stb_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    reg_data_q, reg_data_d;
  logic [7:0]    mem_q [MEM_BYTES];
  logic [7:0]    mem_d [MEM_BYTES];
  logic [7:0]    byte_in, load_byte;

  assign byte_in   = {shift_q[6:0], sda_s};
  assign load_byte = mem_q[ptr_q];

  // bit_cnt_q == 8 in DATA_R marks "ACK seen, next byte loads on the coming SCL fall".
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    ptr_pend_d = ptr_pend_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_d      = mem_q;
    reg_data_d = mem_q[fab.REG_ADDR];

    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) state_d = AACK;
        end
        AACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            if (shift_q[7:1] == ADDRESS) sda_oe_d = 1'b1;
            else                         state_d  = WAIT_STOP;
          end else if (shift_q[0]) begin
            state_d   = DATA_R;
            shift_d   = load_byte;
            sda_oe_d  = ~load_byte[7];
            ptr_d     = ptr_q + 1'b1;
            bit_cnt_d = '0;
          end else begin
            state_d    = DATA_W;
            sda_oe_d   = 1'b0;
            bit_cnt_d  = '0;
            ptr_pend_d = 1'b1;
          end
        end
        DATA_W: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            state_d = DACK_W;
            if (ptr_pend_q) begin
              ptr_d      = byte_in[AW-1:0];
              ptr_pend_d = 1'b0;
            end else begin
              mem_d[ptr_q] = byte_in;
              wr_stb_d     = 1'b1;
              wr_addr_d    = ptr_q;
              wr_data_d    = byte_in;
              ptr_d        = ptr_q + 1'b1;
            end
          end
        end
        DACK_W: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            state_d   = DATA_W;
            bit_cnt_d = '0;
          end
        end
        DATA_R: if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            shift_d   = load_byte;
            sda_oe_d  = ~load_byte[7];
            ptr_d     = ptr_q + 1'b1;
            bit_cnt_d = '0;
          end else if (bit_cnt_q == 4'd7) begin
            sda_oe_d = 1'b0;
            state_d  = DACK_R;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            sda_oe_d  = ~shift_q[6];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        DACK_R: if (scl_rise) begin
          if (sda_s) begin
            state_d = WAIT_STOP;
          end else begin
            state_d   = DATA_R;
            bit_cnt_d = 4'd8;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      ptr_pend_q <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      reg_data_q <= '0;
      for (int i = 0; i < MEM_BYTES; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      ptr_pend_q <= ptr_pend_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      reg_data_q <= reg_data_d;
      mem_q      <= mem_d;
    end
  end

  assign I2C_SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign fab.REG_DATA = reg_data_q;
  assign fab.WR_STB   = wr_stb_q;
  assign fab.WR_ADDR  = wr_addr_q;
  assign fab.WR_DATA  = wr_data_q;
  assign fab.BUSY     = busy_q;
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: bit-banged I2C master, write-strobe
// scoreboard with a decoupled monitor, and direct checks on ACKs and read data.
module tb_i2c_slave_regfile;
  localparam int AW = 4;
  localparam int Q  = 8;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic scl_drv;
  logic sda_low;
  wire  sda_bus;
  int   checks = 0;
  int   errors = 0;
  int   tgt_low_cnt = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;
  wr_t wr_exp[$];
  wr_t mon_e;

  i2c_slave_regfile_if #(.AW(AW)) fab();

  assign sda_bus = sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_slave_regfile dut (
    .BUS_CLK (clk),
    .BUS_RST (rst),
    .I2C_SCL (scl_drv),
    .I2C_SDA (sda_bus),
    .fab     (fab)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wr_exp.push_back(w);
  endtask

  // Every strobe pops one expected write; a strobe held two cycles pops twice.
  always @(negedge clk) begin
    if (!rst && fab.WR_STB === 1'b1) begin
      if (wr_exp.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL wr_stb_unexpected actual addr=%0h data=%0h required no strobe", fab.WR_ADDR, fab.WR_DATA);
      end else begin
        mon_e = wr_exp.pop_front();
        checkOutput("wr_addr", fab.WR_ADDR, mon_e.addr);
        checkOutput("wr_data", fab.WR_DATA, mon_e.data);
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (sda_bus === 1'b0 && !sda_low) tgt_low_cnt++;
  end

  task automatic quarter();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_low = 1'b0; quarter();
    scl_drv = 1'b1; quarter();
    sda_low = 1'b1; quarter();
    scl_drv = 1'b0; quarter();
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; quarter();
    scl_drv = 1'b1; quarter();
    sda_low = 1'b0; quarter();
  endtask

  task automatic write_bit(input bit b, input bit glitch);
    sda_low = ~b; quarter();
    scl_drv = 1'b1;
    if (glitch) begin
      quarter();
      scl_drv = 1'b0;
      @(negedge clk);
      scl_drv = 1'b1;
      repeat (Q - 1) @(negedge clk);
    end else begin
      quarter(); quarter();
    end
    scl_drv = 1'b0; quarter();
  endtask

  task automatic read_bit(output bit b);
    sda_low = 1'b0; quarter();
    scl_drv = 1'b1; quarter();
    b = (sda_bus === 1'b1);
    quarter();
    scl_drv = 1'b0; quarter();
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output bit ack);
    bit nack;
    for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_bit);
    read_bit(nack);
    ack = ~nack;
  endtask

  task automatic read_byte(input bit ack, output logic [7:0] d);
    bit b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~ack, 1'b0);
  endtask

  task automatic applyStimulus(input string name, input logic [7:0] d, input bit exp_ack);
    bit ack;
    write_byte(d, -1, ack);
    checkOutput(name, {31'd0, ack}, {31'd0, exp_ack});
  endtask

  task automatic read_reg(input logic [AW-1:0] a, output logic [7:0] d);
    fab.REG_ADDR = a;
    @(negedge clk);
    d = fab.REG_DATA;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rd;
    bit         ack, b7, b6, b5;

    rst = 1'b1; scl_drv = 1'b1; sda_low = 1'b0; fab.REG_ADDR = '0;
    repeat (5) @(negedge clk);
    checkOutput("rst_busy", fab.BUSY, 0);
    checkOutput("rst_wr_stb", fab.WR_STB, 0);
    checkOutput("rst_wr_addr", fab.WR_ADDR, 0);
    checkOutput("rst_wr_data", fab.WR_DATA, 0);
    checkOutput("rst_reg_data", fab.REG_DATA, 0);
    checkOutput("rst_sda", sda_bus, 1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] write pointer 3, data A5 5A");
    expect_wr(4'd3, 8'hA5);
    expect_wr(4'd4, 8'h5A);
    i2c_start();
    checkOutput("t1_busy_high", fab.BUSY, 1);
    applyStimulus("t1_ack_addr", 8'h92, 1'b1);
    applyStimulus("t1_ack_ptr", 8'h03, 1'b1);
    applyStimulus("t1_ack_d0", 8'hA5, 1'b1);
    applyStimulus("t1_ack_d1", 8'h5A, 1'b1);
    i2c_stop();
    checkOutput("t1_busy_low", fab.BUSY, 0);
    read_reg(4'd4, rd); checkOutput("t1_reg4", rd, 8'h5A);
    read_reg(4'd3, rd); checkOutput("t1_reg3", rd, 8'hA5);

    $display("[TB] repeated start read");
    i2c_start();
    applyStimulus("t2_ack_addr_w", 8'h92, 1'b1);
    applyStimulus("t2_ack_ptr", 8'h03, 1'b1);
    i2c_start();
    applyStimulus("t2_ack_addr_r", 8'h93, 1'b1);
    read_byte(1'b1, rd); checkOutput("t2_rd0", rd, 8'hA5);
    read_byte(1'b0, rd); checkOutput("t2_rd1", rd, 8'h5A);
    checkOutput("t2_release_after_nack", sda_bus, 1);
    checkOutput("t2_busy_before_stop", fab.BUSY, 1);
    i2c_stop();
    checkOutput("t2_busy_low", fab.BUSY, 0);

    $display("[TB] non-matching address");
    tgt_low_cnt = 0;
    i2c_start();
    applyStimulus("t3_nack_addr", 8'h94, 1'b0);
    applyStimulus("t3_nack_data", 8'h00, 1'b0);
    checkOutput("t3_never_driven", tgt_low_cnt, 0);
    checkOutput("t3_busy_high", fab.BUSY, 1);
    i2c_stop();
    checkOutput("t3_busy_low", fab.BUSY, 0);

    $display("[TB] pointer wrap");
    expect_wr(4'd15, 8'h11);
    expect_wr(4'd0, 8'h22);
    i2c_start();
    applyStimulus("t4_ack_addr", 8'h92, 1'b1);
    applyStimulus("t4_ack_ptr", 8'h0F, 1'b1);
    applyStimulus("t4_ack_d0", 8'h11, 1'b1);
    applyStimulus("t4_ack_d1", 8'h22, 1'b1);
    i2c_stop();
    read_reg(4'd15, rd); checkOutput("t4_reg15", rd, 8'h11);
    read_reg(4'd0, rd);  checkOutput("t4_reg0", rd, 8'h22);

    $display("[TB] reset during read bit 4");
    i2c_start();
    applyStimulus("t5_ack_addr_w", 8'h92, 1'b1);
    applyStimulus("t5_ack_ptr", 8'h03, 1'b1);
    i2c_start();
    applyStimulus("t5_ack_addr_r", 8'h93, 1'b1);
    read_bit(b7); read_bit(b6); read_bit(b5);
    checkOutput("t5_bits_765", {29'd0, b7, b6, b5}, 32'h5);
    scl_drv = 1'b1; quarter();
    checkOutput("t5_bit4_driven_low", sda_bus, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_rst_release", sda_bus, 1);
    checkOutput("t5_rst_busy", fab.BUSY, 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      read_reg(i[AW-1:0], rd);
      checkOutput($sformatf("t5_cleared_%0d", i), rd, 0);
    end
    scl_drv = 1'b0; quarter();
    i2c_stop();
    expect_wr(4'd5, 8'h77);
    i2c_start();
    applyStimulus("t5_post_ack_addr", 8'h92, 1'b1);
    applyStimulus("t5_post_ack_ptr", 8'h05, 1'b1);
    applyStimulus("t5_post_ack_d0", 8'h77, 1'b1);
    i2c_stop();
    read_reg(4'd5, rd); checkOutput("t5_post_reg5", rd, 8'h77);

    $display("[TB] one-cycle SCL glitch inside address bit 5");
    if (FILT) expect_wr(4'd7, 8'h3C);
    i2c_start();
    write_byte(8'h92, 5, ack);
    checkOutput("t6_ack_addr", {31'd0, ack}, {31'd0, FILT});
    applyStimulus("t6_ack_ptr", 8'h07, FILT);
    applyStimulus("t6_ack_d0", 8'h3C, FILT);
    i2c_stop();
    checkOutput("t6_busy_low", fab.BUSY, 0);

    repeat (10) @(negedge clk);
    checkOutput("wr_queue_empty", wr_exp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
